rv_muldiv_unit: RTL and testbench
=================================

Name: rv_muldiv_unit

Overview:
Iterative RV32M/RV64M multiply/divide execution unit. It sits beside the single-cycle ALU in the next-generation datapath, and the control unit stalls the PC while the unit is busy. It is parametrised in XLEN and uses a start/busy/done handshake. It implements MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU with RISC-V-exact corner-case results.

Parameters:
XLEN, 32, operand and result width; legal values are 32 and 64.
CNT_W, $clog2(XLEN)+1, width of the iteration counter; derived, do not override.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only when busy=0
op  input  3  funct3 of the M instruction: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
a  input  XLEN  rs1 operand; captured at the accepted start
b  input  XLEN  rs2 operand; captured at the accepted start
kill  input  1  synchronous abort (pipeline flush)
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse; result is valid
result  output  XLEN  final result; held until the next accepted start

Behaviour:
- Clock and reset: clk rising edge; reset is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0. All internal operand, accumulator and counter registers are cleared.
- FSM states:
  - IDLE: accepts start.
  - PREP: takes absolute values of signed operands and records the result sign.
  - CALC: runs XLEN iterations. Multiply is shift-add; divide is restoring, one quotient bit per cycle.
  - FIX: applies sign correction and selects the high/low or quotient/remainder part.
  - DONE: asserts done.
- Transitions:
  - IDLE→PREP on start.
  - PREP→CALC.
  - CALC→FIX when the counter reaches XLEN-1.
  - FIX→DONE.
  - DONE→PREP if start, otherwise DONE→IDLE.
- Latency: start is sampled at edge E0. done is high in the cycle after edge E0+XLEN+2, i.e. the 34th edge for XLEN=32. Back-to-back operation is allowed: start asserted during DONE is accepted, so throughput is one operation per XLEN+3 cycles.
- busy: high in PREP, CALC and FIX; low in IDLE and DONE. start while busy=1 is ignored, and its operands are not captured.
- result: updated only on the FIX→DONE transition; stable at all other times.
- Signedness:
  - MULH: a and b signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
  - DIV, REM: both signed.
- Product width: the internal product is 2*XLEN bits. MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- Divide by zero:
  - DIV/DIVU quotient = all ones.
  - REM/REMU remainder = a.
- Signed overflow (a = most-negative value, b = -1):
  - DIV quotient = a.
  - REM remainder = 0.
- Remainder sign follows the dividend; quotient truncates toward zero.
- kill: in any state, the next edge returns the FSM to IDLE. done is not asserted and result is unchanged. kill has priority over start in the same cycle.
- Reset mid-operation: immediate return to IDLE; all outputs take their reset values.

Optional Feature:
Macro: MULDIV_EARLY_OUT_EN.
- Defined: the following cases go IDLE→DONE directly (or DONE→DONE on back-to-back), with done one cycle after the start edge and busy staying low:
  - divide by zero;
  - signed overflow;
  - any multiply with a==0 or b==0.
  These results are computed combinationally at capture and are identical to the full-path results.
- Not defined: every operation takes the fixed XLEN+3-cycle path. Result values are identical in both builds.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) → result 0xFFFFFFEB; done exactly 34 edges after start; busy high from edge 1 through edge 33.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFE. MULH with the same operands → 0x00000000. MULHSU a=-1, b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV a=-7, b=2 → quotient 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU a=100, b=7 → 14. REMU a=100, b=7 → 2.
- DIV a=5, b=0 → 0xFFFFFFFF; REM a=5, b=0 → 5; DIV a=0x80000000, b=-1 → 0x80000000; REM with the same operands → 0. With MULDIV_EARLY_OUT_EN defined, done comes 1 cycle after start; without it, 34 cycles.
- Back-to-back: start in the DONE cycle is accepted. A start pulse at edge 10 of an operation in flight is ignored. kill at edge 20 → IDLE, no done, result keeps its previous value.
- Reset asserted mid-CALC → busy=0, done=0, result=0 immediately. The first start after deassertion completes normally.

Source files
------------

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Latency: done is high in the cycle after edge start+XLEN+2; early-out cases finish right after the start edge.
// Backpressure: start is accepted only while busy=0 (IDLE or DONE); kill aborts to IDLE from any state.
// Optional build macro: MULDIV_EARLY_OUT_EN (short-circuits divide-by-zero, signed overflow and zero multiplies).
module rv_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   opnd;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] prod;     // mul: {acc, multiplier}; div: {remainder, dividend/quotient}
    logic [CNT_W-1:0]  cnt;

    logic              accept;
    logic              a_sgn;
    logic              b_sgn;
    logic              a_neg;
    logic              b_neg;
    logic              q_neg;
    logic              b_zero;
    logic [XLEN-1:0]   a_abs;
    logic [XLEN-1:0]   b_abs;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_nxt;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_sub;
    logic [2*XLEN-1:0] div_nxt;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_val;
    logic              early_hit;

    assign busy   = (state == S_PREP) || (state == S_CALC) || (state == S_FIX);
    assign done   = (state == S_DONE);
    assign accept = start && !kill && ((state == S_IDLE) || (state == S_DONE));

    // Operand signedness and magnitudes derived from the captured instruction.
    always_comb begin
        a_sgn  = (op_q == 3'd1) || (op_q == 3'd2) || (op_q == 3'd4) || (op_q == 3'd6);
        b_sgn  = (op_q == 3'd1) || (op_q == 3'd4) || (op_q == 3'd6);
        a_neg  = a_sgn && a_q[XLEN-1];
        b_neg  = b_sgn && b_q[XLEN-1];
        q_neg  = a_neg ^ b_neg;
        b_zero = (b_q == '0);
        a_abs  = a_neg ? -a_q : a_q;
        b_abs  = b_neg ? -b_q : b_q;
    end

    // One shift-add multiply step and one restoring-divide step on the shared product register.
    always_comb begin
        mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opnd} : '0);
        mul_nxt   = {mul_sum, prod[XLEN-1:1]};
        div_shift = prod[2*XLEN-1:XLEN-1];
        div_ge    = (div_shift >= {1'b0, opnd});
        div_sub   = div_shift[XLEN-1:0] - opnd;
        div_nxt   = {(div_ge ? div_sub : div_shift[XLEN-1:0]), prod[XLEN-2:0], div_ge};
    end

    // Sign correction and part selection; divide-by-zero quotient is forced to all ones.
    always_comb begin
        prod_fix = q_neg ? -prod : prod;
        quo      = prod[XLEN-1:0];
        rem      = prod[2*XLEN-1:XLEN];
        fix_val  = '0;
        case (op_q)
            3'd0:    fix_val = prod_fix[XLEN-1:0];
            3'd1,
            3'd2,
            3'd3:    fix_val = prod_fix[2*XLEN-1:XLEN];
            3'd4:    fix_val = b_zero ? '1 : (q_neg ? -quo : quo);
            3'd5:    fix_val = quo;
            3'd6:    fix_val = a_neg ? -rem : rem;
            default: fix_val = rem;
        endcase
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic [XLEN-1:0] early_val;
    logic            early_div0;
    logic            early_ovf;

    // Results that need no iteration, computed straight from the incoming operands.
    always_comb begin
        early_div0 = (b == '0);
        early_ovf  = !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        early_hit  = 1'b0;
        early_val  = '0;
        if (op[2]) begin
            if (early_div0) begin
                early_hit = 1'b1;
                early_val = op[1] ? a : '1;
            end else if (early_ovf) begin
                early_hit = 1'b1;
                early_val = op[1] ? '0 : a;
            end
        end else if ((a == '0) || (b == '0)) begin
            early_hit = 1'b1;
            early_val = '0;
        end
    end
`else
    assign early_hit = 1'b0;
`endif

    // Next-state selection; kill overrides everything.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = early_hit ? S_DONE : S_PREP;
            end
            S_DONE: begin
                if (accept) state_nxt = early_hit ? S_DONE : S_PREP;
                else        state_nxt = S_IDLE;
            end
            S_PREP:  state_nxt = S_CALC;
            S_CALC:  state_nxt = (cnt == CNT_LAST) ? S_FIX : S_CALC;
            S_FIX:   state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
        if (kill) state_nxt = S_IDLE;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            opnd   <= '0;
            prod   <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            if (accept) begin
                op_q <= op;
                a_q  <= a;
                b_q  <= b;
`ifdef MULDIV_EARLY_OUT_EN
                if (early_hit) result <= early_val;
`endif
            end
            case (state)
                S_PREP: begin
                    opnd <= op_q[2] ? b_abs : a_abs;
                    prod <= {{XLEN{1'b0}}, (op_q[2] ? a_abs : b_abs)};
                    cnt  <= '0;
                end
                S_CALC: begin
                    prod <= op_q[2] ? div_nxt : mul_nxt;
                    cnt  <= cnt + CNT_W'(1);
                end
                S_FIX: begin
                    if (!kill) result <= fix_val;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Self-checking bench for rv_muldiv_unit (XLEN=32): directed vector table, corner sequences, random vs reference model.
// Latency: full path done after start edge + 34 edges; early-out path (when built in) right after the start edge.
// Backpressure: every new start is issued only when busy=0 (idle or the DONE cycle of the previous op).
module tb_rv_muldiv_unit;

    localparam int XLEN     = 32;
    localparam int FULL_LAT = XLEN + 2;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            kill;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    rv_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .kill   (kill),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [0:17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: full-width two's complement arithmetic with the RISC-V special cases.
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] sx;
        logic [63:0] sy;
        logic [63:0] ux;
        logic [63:0] uy;
        logic [63:0] p;
        int signed   ix;
        int signed   iy;
        logic        ovf;
        sx  = {{32{x[31]}}, x};
        sy  = {{32{y[31]}}, y};
        ux  = {32'd0, x};
        uy  = {32'd0, y};
        ix  = x;
        iy  = y;
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = sx * sy; return p[31:0];  end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf)    return x;
                return 32'(ix / iy);
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (ovf)    return 32'd0;
                return 32'(ix % iy);
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic bit exp_early(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (!EARLY) return 1'b0;
        if (o[2]) return (y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
        return (x == 0) || (y == 0);
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue one op (called at #1 after an edge), follow it for at most 60 edges.
    // spur_at/kill_at inject a spurious start / kill before the edge following sample n.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int spur_at, input int kill_at,
                          output logic [31:0] res, output int lat, output int bcnt);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = -1;
        bcnt  = 0;
        for (int n = 0; n < 60; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            if (busy) bcnt++;
            if (n == spur_at) begin
                start = 1'b1;
                op    = 3'd0;
                a     = 32'd3;
                b     = 32'd3;
            end
            if (n == kill_at) kill = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            kill  = 1'b0;
        end
        res = result;
    endtask

    task automatic run_checked(input string tag, input logic [2:0] o, input logic [31:0] x,
                               input logic [31:0] y, input logic [31:0] exp);
        logic [31:0] res;
        int          lat;
        int          bcnt;
        bit          e;
        e = exp_early(o, x, y);
        run_op(o, x, y, -1, -1, res, lat, bcnt);
        check({tag, " result"}, 64'(res), 64'(exp));
        check({tag, " latency"}, 64'(lat), e ? 64'd0 : 64'(FULL_LAT));
        check({tag, " busy cycles"}, 64'(bcnt), e ? 64'd0 : 64'(FULL_LAT));
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        int          bcnt;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2};
        vecs[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
        vecs[12] = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[13] = '{3'd7, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9};
        vecs[14] = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        vecs[15] = '{3'd0, 32'd0,          32'd12345,     32'd0};
        vecs[16] = '{3'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[17] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};

        reset = 1'b1;
        start = 1'b0;
        kill  = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",   64'(busy),   64'd0);
        check("reset done",   64'(done),   64'd0);
        check("reset result", 64'(result), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed table; each op after the first starts in the previous op's DONE cycle.
        for (int i = 0; i <= 17; i++)
            run_checked($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

        // With no further start, done is a single pulse and the unit returns idle.
        @(posedge clk); #1;
        check("done pulse width", 64'(done), 64'd0);
        check("idle after done",  64'(busy), 64'd0);

        // Spurious start while busy must be ignored.
        run_op(3'd5, 32'd100, 32'd7, 9, -1, res, lat, bcnt);
        check("spur result",  64'(res),  64'd14);
        check("spur latency", 64'(lat),  64'(FULL_LAT));
        check("spur busy",    64'(bcnt), 64'(FULL_LAT));

        // Kill mid-calculation: no done, result retained, back to idle.
        run_op(3'd0, 32'd1234, 32'd5678, -1, 19, res, lat, bcnt);
        check("kill no done", 64'(lat),  64'hFFFF_FFFF_FFFF_FFFF);
        check("kill result",  64'(res),  64'd14);
        check("kill busy",    64'(busy), 64'd0);
        run_checked("after kill", 3'd0, 32'd1234, 32'd5678, 32'd7006652);

        // Asynchronous reset in the middle of CALC.
        op    = 3'd7;
        a     = 32'd1000;
        b     = 32'd33;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midreset busy",   64'(busy),   64'd0);
        check("midreset done",   64'(done),   64'd0);
        check("midreset result", 64'(result), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_checked("after reset", 3'd7, 32'd1000, 32'd33, 32'd10);

        // Random operations against the reference model.
        for (int i = 0; i < 80; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = rnd_opnd();
            rb = rnd_opnd();
            run_checked($sformatf("rnd%0d op%0d a=%h b=%h", i, ro, ra, rb), ro, ra, rb, ref_model(ro, ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
